// File: rtl/mem_line_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory line arbiter.
package mem_line_arbiter_pkg;

  localparam int ARB_LINE_W   = 256;
  localparam int ARB_OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_line_arbiter_pick.sv
// Combinational winner select for the memory line arbiter.
// Build option: define ARB_ROUND_ROBIN_EN to alternate between requesters on
// simultaneous requests; otherwise the dcache always wins a tie.
module arb_pick
  import mem_line_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_owner_i,
  output logic grant_valid_o,
  output logic grant_owner_o
);

  // Pick a single winner among the (already masked) requests
  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_owner_o = ICACHE;
    if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_owner_o = (last_owner_i == DCACHE) ? ICACHE : DCACHE;
`else
      grant_owner_o = DCACHE;
`endif
    end else if (d_req_i) begin
      grant_owner_o = DCACHE;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // last_owner only steers ties in the round-robin build
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one line-granular memory port between icache (read) and dcache
// (read / writeback). One transaction in flight; grant is registered, response
// and read data are forwarded combinationally to the owner.
// Build option: ARB_ROUND_ROBIN_EN (see arb_pick).
//
//   state  | meaning
//   IDLE   | sample masked requests, latch the winner's transaction
//   I_BUSY | icache transaction on the memory port, waiting for mem_resp
//   D_BUSY | dcache transaction on the memory port, waiting for mem_resp
//   GAP    | one dead cycle so the served cache can drop its request
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int LINE_W   = ARB_LINE_W,
  parameter int OFFSET_W = ARB_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  arb_owner_t        last_owner_q, last_owner_d;
  arb_owner_t        gap_owner_q, gap_owner_d;
  logic              gap_valid_q, gap_valid_d;
  logic [31:0]       addr_q, addr_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic       i_req_m, d_req_m;
  logic       grant_valid;
  logic       grant_owner;
  logic       busy;
  arb_owner_t busy_owner;

  // The cache just served drops its request one cycle late, so hide it
  // through GAP and the IDLE cycle that follows.
  assign i_req_m = i_read && !(gap_valid_q && gap_owner_q == ICACHE);
  assign d_req_m = (d_read || d_write) && !(gap_valid_q && gap_owner_q == DCACHE);

  assign busy       = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign busy_owner = (state_q == D_BUSY) ? DCACHE : ICACHE;

  arb_pick u_pick (
    .i_req_i       (i_req_m),
    .d_req_i       (d_req_m),
    .last_owner_i  (last_owner_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = (grant_owner == DCACHE) ? D_BUSY : I_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the latched transaction, ownership history and gap mask
  always_comb begin
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    last_owner_d = last_owner_q;
    gap_valid_d  = gap_valid_q;
    gap_owner_d  = gap_owner_q;
    case (state_q)
      IDLE: begin
        gap_valid_d = 1'b0;
        if (grant_valid) begin
          if (grant_owner == DCACHE) begin
            // read+write together is resolved as a writeback
            addr_d  = {d_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            write_d = d_write;
            wdata_d = d_write ? d_wdata : '0;
          end else begin
            addr_d  = {i_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            write_d = 1'b0;
            wdata_d = '0;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          gap_valid_d  = 1'b1;
          gap_owner_d  = busy_owner;
          last_owner_d = busy_owner;
        end
      end
      default: ;
    endcase
  end

  // Transaction and history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      last_owner_q <= ICACHE;
      gap_valid_q  <= 1'b0;
      gap_owner_q  <= ICACHE;
    end else begin
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      last_owner_q <= last_owner_d;
      gap_valid_q  <= gap_valid_d;
      gap_owner_q  <= gap_owner_d;
    end
  end

  // FSM outputs: memory port from latches, response steered to the owner
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    if (busy) begin
      mem_read  = !write_q;
      mem_write = write_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (mem_resp) begin
        if (state_q == D_BUSY) begin
          d_resp  = 1'b1;
          d_rdata = mem_rdata;
        end else begin
          i_resp  = 1'b1;
          i_rdata = mem_rdata;
        end
      end
    end
  end

  // Offset bits never reach the memory port
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0]};

  // The dcache should never read and write at once
  dcache_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(d_read && d_write));

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter. Inputs change 1 ns after the rising
// edge, outputs are checked 2 ns after it.
module tb_mem_line_arbiter;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_addr, d_addr, mem_addr;
  logic          i_read, i_resp, d_read, d_write, d_resp;
  logic          mem_read, mem_write, mem_resp;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  int total  = 0;
  int passed = 0;

  logic [LW-1:0] pat_a5, pat_beef, pat_r1, pat_r2, pat_r3, pat_r4, pat_junk;
  logic          d_first;
  logic [31:0]   first_addr, second_addr;

  mem_line_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_read    (i_read),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_addr    (d_addr),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, ".mem_read"},  LW'(mem_read),  '0);
    check({tag, ".mem_write"}, LW'(mem_write), '0);
    check({tag, ".i_resp"},    LW'(i_resp),    '0);
    check({tag, ".d_resp"},    LW'(d_resp),    '0);
    check({tag, ".mem_addr"},  LW'(mem_addr),  '0);
    check({tag, ".mem_wdata"}, mem_wdata,      '0);
    check({tag, ".i_rdata"},   i_rdata,        '0);
    check({tag, ".d_rdata"},   d_rdata,        '0);
  endtask

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_beef = {8{32'hDEADBEEF}};
    pat_r1   = {16{16'h1234}};
    pat_r2   = {32{8'h3C}};
    pat_r3   = {8{32'hCAFEF00D}};
    pat_r4   = {64{4'h7}};
    pat_junk = {8{32'h1111_2222}};

    rst = 1'b0; i_read = 1'b1; i_addr = 32'h0000_1234;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;

    // reset held two cycles with an icache request pending
    nxt(); #1; all_zero("rst1");
    nxt(); #1; all_zero("rst2");
    rst = 1'b1;

    // one cycle after release the icache read is on the port
    nxt(); #1;
    check("rel.mem_read",  LW'(mem_read),  LW'(1));
    check("rel.mem_write", LW'(mem_write), '0);
    check("rel.mem_addr",  LW'(mem_addr),  LW'(32'h0000_1220));
    nxt();
    nxt(); #1;
    check("ird.hold_read", LW'(mem_read), LW'(1));
    check("ird.hold_addr", LW'(mem_addr), LW'(32'h0000_1220));
    nxt();
    mem_resp = 1'b1; mem_rdata = pat_a5; #1;
    check("ird.i_resp",  LW'(i_resp), LW'(1));
    check("ird.i_rdata", i_rdata,     pat_a5);
    check("ird.d_resp",  LW'(d_resp), '0);
    check("ird.d_rdata", d_rdata,     '0);
    // GAP: a stray response here must be ignored; icache drops late
    nxt(); #1;
    check("gap.mem_read", LW'(mem_read), '0);
    check("gap.i_resp",   LW'(i_resp),   '0);
    check("gap.i_rdata",  i_rdata,       '0);
    mem_resp = 1'b0; i_read = 1'b0;
    nxt();
    nxt(); #1;
    check("idle.no_read", LW'(mem_read), '0);

    // dcache writeback, inputs change mid-transaction
    d_write = 1'b1; d_addr = 32'h0000_2040; d_wdata = pat_beef;
    nxt(); #1;
    check("dwb.mem_write", LW'(mem_write), LW'(1));
    check("dwb.mem_read",  LW'(mem_read),  '0);
    check("dwb.mem_addr",  LW'(mem_addr),  LW'(32'h0000_2040));
    check("dwb.mem_wdata", mem_wdata,      pat_beef);
    d_wdata = pat_junk; d_addr = 32'h9999_9999;
    nxt(); #1;
    check("dwb.wdata_hold", mem_wdata,     pat_beef);
    check("dwb.addr_hold",  LW'(mem_addr), LW'(32'h0000_2040));
    mem_resp = 1'b1; mem_rdata = pat_r4; #1;
    check("dwb.d_resp", LW'(d_resp), LW'(1));
    check("dwb.i_resp", LW'(i_resp), '0);
    nxt();
    mem_resp = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; #1;
    check("dwb.write_drop", LW'(mem_write), '0);
    check("dwb.d_resp_end", LW'(d_resp),    '0);
    nxt();
    nxt();

    // late deassert: d_read stays up through GAP and the following IDLE
    d_read = 1'b1; d_addr = 32'h0000_6010;
    nxt(); #1;
    check("late.mem_read", LW'(mem_read), LW'(1));
    check("late.mem_addr", LW'(mem_addr), LW'(32'h0000_6000));
    mem_resp = 1'b1; mem_rdata = pat_r1; #1;
    check("late.d_resp",  LW'(d_resp), LW'(1));
    check("late.d_rdata", d_rdata,     pat_r1);
    nxt();
    mem_resp = 1'b0; #1;
    check("late.gap_read", LW'(mem_read), '0);
    nxt(); #1;
    check("late.idle_read", LW'(mem_read), '0);
    d_read = 1'b0;
    nxt(); #1;
    check("late.no_reissue1", LW'(mem_read), '0);
    nxt(); #1;
    check("late.no_reissue2", LW'(mem_read), '0);

    // simultaneous requests; the last owner was the dcache
`ifdef ARB_ROUND_ROBIN_EN
    d_first = 1'b0; first_addr = 32'h0000_3000; second_addr = 32'h0000_4000;
`else
    d_first = 1'b1; first_addr = 32'h0000_4000; second_addr = 32'h0000_3000;
`endif
    i_read = 1'b1; i_addr = 32'h0000_3004;
    d_read = 1'b1; d_addr = 32'h0000_4008;
    nxt(); #1;
    check("both.first_read", LW'(mem_read), LW'(1));
    check("both.first_addr", LW'(mem_addr), LW'(first_addr));
    mem_resp = 1'b1; mem_rdata = pat_r2; #1;
    check("both.first_d_resp", LW'(d_resp), LW'(d_first));
    check("both.first_i_resp", LW'(i_resp), LW'(!d_first));
    check("both.first_rdata",  d_first ? d_rdata : i_rdata, pat_r2);
    check("both.other_rdata",  d_first ? i_rdata : d_rdata, '0);
    nxt();
    mem_resp = 1'b0; #1;
    check("both.gap_read", LW'(mem_read), '0);
    nxt();
    if (d_first) d_read = 1'b0; else i_read = 1'b0;
    #1;
    check("both.idle_read", LW'(mem_read), '0);
    nxt(); #1;
    check("both.m3_read", LW'(mem_read), LW'(1));
    check("both.m3_addr", LW'(mem_addr), LW'(second_addr));
    mem_resp = 1'b1; mem_rdata = pat_r3; #1;
    check("both.second_d_resp", LW'(d_resp), LW'(!d_first));
    check("both.second_i_resp", LW'(i_resp), LW'(d_first));
    check("both.second_rdata",  d_first ? i_rdata : d_rdata, pat_r3);
    nxt();
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; #1;
    check("both.end_read", LW'(mem_read), '0);
    nxt();
    nxt();

    // reset while the dcache owns the port, then a stray response
    d_read = 1'b1; d_addr = 32'h0000_5000;
    nxt(); #1;
    check("mrst.busy_read", LW'(mem_read), LW'(1));
    rst = 1'b0; d_read = 1'b0;
    nxt(); #1;
    all_zero("mrst");
    rst = 1'b1;
    nxt();
    nxt();
    mem_resp = 1'b1; mem_rdata = pat_r4; #1;
    check("stray.d_resp",  LW'(d_resp), '0);
    check("stray.i_resp",  LW'(i_resp), '0);
    check("stray.d_rdata", d_rdata,     '0);
    nxt();
    mem_resp = 1'b0; #1;
    check("stray.mem_read",  LW'(mem_read),  '0);
    check("stray.mem_write", LW'(mem_write), '0);
    nxt(); #1;
    check("stray.still_idle", LW'(mem_read | mem_write), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
